multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Multi-cycle main control FSM for the 32-bit CPU datapath.
- Sits directly upstream of the ALU: decodes the latched instruction and drives ALUC, ALUSrcB, and all datapath write strobes.
- Consumes the ALU Zero flag to resolve the blt branch.
- Sequences each instruction through IF/ID/EXE/MEM/WB states.

Parameters:
- OP_W, 6, opcode/funct field width.
- ST_W, 3, state register width.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- OpCode  input  6  instr[31:26] from the instruction register.
- Funct  input  6  instr[5:0] from the instruction register.
- Zero  input  1  ALU result-is-zero flag.
- PCWre  output  1  PC write enable.
- PCSrc  output  2  next PC select: 00 PC+4, 01 branch target, 10 jump target.
- IRWre  output  1  instruction register write enable.
- ALUSrcB  output  1  ALU in2 select: 0 register rt, 1 sign-extended immediate.
- ALUC  output  3  ALU operation: 000 add, 010 slt, 100 and, 101 slti.
- MemRd  output  1  data memory read.
- MemWr  output  1  data memory write.
- RegWre  output  1  register file write enable.
- RegDst  output  1  write register select: 0 rt, 1 rd.
- DBDataSrc  output  1  write-back source select: 0 ALU Out, 1 memory data.
- State  output  3  current state, for debug.
- Halted  output  1  high while in HALT.

Behaviour:
- Reset is asynchronous, active-high:
  - State goes to IF (000) immediately.
  - While Reset is high, every output is forced to 0, IRWre included.
  - Operation starts in IF on the first rising CLK edge after Reset falls.
- State encoding: IF 000, ID 001, EXE 010, MEM 011, WB 100, HALT 111.
- Outputs are combinational from State, OpCode, Funct and Zero. OpCode and Funct are stable from ID until the next IF.
- Decode table:
  - R-type (000000): Funct 100000 add, 100100 and, 101010 slt.
  - 001000 addi, 001100 andi, 001010 slti.
  - 100011 lw, 101011 sw, 000100 blt (branch if rs < rt), 000010 j, 111111 halt.
  - Anything else is illegal, including R-type with an unlisted Funct.
- IF: IRWre=1. Next state ID.
- ID:
  - halt -> HALT.
  - j -> IF, with PCWre=1, PCSrc=10.
  - illegal -> IF, with PCWre=1, PCSrc=00 (executes as a NOP).
  - otherwise -> EXE.
- EXE: ALUC and ALUSrcB are driven per decode. ALUSrcB=1 for addi, andi, slti, lw, sw.
  - R-type, addi, andi, slti -> WB.
  - lw, sw -> MEM.
  - blt -> IF, with ALUC=010 and PCWre=1. PCSrc=01 if Zero=0 (slt result is 1, branch taken), else PCSrc=00.
- MEM:
  - lw: MemRd=1 -> WB.
  - sw: MemWr=1, PCWre=1, PCSrc=00 -> IF.
- WB: RegWre=1, PCWre=1, PCSrc=00 -> IF.
  - RegDst=1 for R-type only.
  - DBDataSrc=1 for lw only.
- HALT: all strobes 0, Halted=1. HALT is left only via Reset.
- ALUC mapping:
  - add, addi, lw, sw -> 000.
  - slt, blt -> 010.
  - and, andi -> 100.
  - slti -> 101.
  - ALUC holds its decoded value in EXE, MEM and WB; it is 000 in IF, ID and HALT.
  - ALUSrcB holds its decoded value in EXE, MEM and WB; it is 0 elsewhere.
- Strobe exclusivity: MemRd, MemWr, RegWre, IRWre each assert for exactly one cycle per instruction, never together. PCWre asserts exactly once per instruction, in its final cycle.
- Instruction latency in cycles:
  - R-type and I-arithmetic: 4.
  - lw: 5.
  - sw: 4.
  - blt: 3.
  - j: 2.
  - illegal: 2.
  - halt: 2 cycles to reach HALT, then stays.
- Reset mid-instruction: no partial strobe may be observed after Reset rises; the FSM restarts at IF.

Test Plan:
- Reset held 3 cycles, released; OpCode=000000, Funct=100000 -> State 000,001,010,100,000. IRWre=1 in cycle 1. ALUC=000 in EXE/WB. RegWre=1, RegDst=1, PCWre=1 in WB only.
- lw (100011) -> 5-cycle sequence IF,ID,EXE,MEM,WB. ALUSrcB=1, ALUC=000 from EXE to WB. MemRd=1 in MEM. RegWre=1, DBDataSrc=1, RegDst=0 in WB.
- blt (000100) with Zero=0 in EXE -> ALUC=010, PCWre=1, PCSrc=01, next State IF. Repeat with Zero=1 -> PCSrc=00.
- j (000010) -> PCWre=1, PCSrc=10 in ID, next State IF. Illegal opcode 111000 -> PCWre=1, PCSrc=00 in ID, no other strobe.
- slti (001010) then andi (001100) -> ALUC=101 and then 100 respectively, ALUSrcB=1, RegWre in WB.
- halt (111111) -> State 111, Halted=1 for 20 cycles with no strobes. Then assert Reset asynchronously mid-MEM of an sw -> MemWr drops to 0 immediately, State=000.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM: walks each instruction through IF/ID/EXE/MEM/WB.
// In: CLK, Reset, OpCode, Funct, Zero. Out: datapath strobes, ALUC, State, Halted.
module multicycle_control #(
   parameter int OP_W = 6,
   parameter int ST_W = 3
) (
   input  logic            CLK,
   input  logic            Reset,
   input  logic [OP_W-1:0] OpCode,
   input  logic [OP_W-1:0] Funct,
   input  logic            Zero,
   output logic            PCWre,
   output logic [1:0]      PCSrc,
   output logic            IRWre,
   output logic            ALUSrcB,
   output logic [2:0]      ALUC,
   output logic            MemRd,
   output logic            MemWr,
   output logic            RegWre,
   output logic            RegDst,
   output logic            DBDataSrc,
   output logic [ST_W-1:0] State,
   output logic            Halted
);

   typedef enum logic [ST_W-1:0] {
      S_IF   = 3'b000,
      S_ID   = 3'b001,
      S_EXE  = 3'b010,
      S_MEM  = 3'b011,
      S_WB   = 3'b100,
      S_HALT = 3'b111
   } state_e;

   localparam logic [OP_W-1:0] OP_R    = 6'b000000;
   localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
   localparam logic [OP_W-1:0] OP_ANDI = 6'b001100;
   localparam logic [OP_W-1:0] OP_SLTI = 6'b001010;
   localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
   localparam logic [OP_W-1:0] OP_BLT  = 6'b000100;
   localparam logic [OP_W-1:0] OP_J    = 6'b000010;
   localparam logic [OP_W-1:0] OP_HALT = 6'b111111;

   localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
   localparam logic [OP_W-1:0] FN_AND = 6'b100100;
   localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SLT  = 3'b010;
   localparam logic [2:0] ALU_AND  = 3'b100;
   localparam logic [2:0] ALU_SLTI = 3'b101;

   state_e state_q;
   state_e state_d;

   logic       is_r;
   logic       is_ld;
   logic       is_st;
   logic       is_br;
   logic       is_jmp;
   logic       is_hlt;
   logic       is_ill;
   logic [2:0] dec_aluc;
   logic       dec_srcb;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) state_q <= S_IF;
      else       state_q <= state_d;
   end

   assign State = state_q;

   always_comb begin
      is_r     = 1'b0;
      is_ld    = 1'b0;
      is_st    = 1'b0;
      is_br    = 1'b0;
      is_jmp   = 1'b0;
      is_hlt   = 1'b0;
      is_ill   = 1'b0;
      dec_aluc = ALU_ADD;
      dec_srcb = 1'b0;
      case (OpCode)
         OP_R: begin
            is_r = 1'b1;
            case (Funct)
               FN_ADD:  dec_aluc = ALU_ADD;
               FN_AND:  dec_aluc = ALU_AND;
               FN_SLT:  dec_aluc = ALU_SLT;
               default: begin
                  is_r   = 1'b0;
                  is_ill = 1'b1;
               end
            endcase
         end
         OP_ADDI: dec_srcb = 1'b1;
         OP_ANDI: begin
            dec_srcb = 1'b1;
            dec_aluc = ALU_AND;
         end
         OP_SLTI: begin
            dec_srcb = 1'b1;
            dec_aluc = ALU_SLTI;
         end
         OP_LW: begin
            is_ld    = 1'b1;
            dec_srcb = 1'b1;
         end
         OP_SW: begin
            is_st    = 1'b1;
            dec_srcb = 1'b1;
         end
         OP_BLT: begin
            is_br    = 1'b1;
            dec_aluc = ALU_SLT;
         end
         OP_J:    is_jmp = 1'b1;
         OP_HALT: is_hlt = 1'b1;
         default: is_ill = 1'b1;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      PCWre     = 1'b0;
      PCSrc     = 2'b00;
      IRWre     = 1'b0;
      ALUSrcB   = 1'b0;
      ALUC      = ALU_ADD;
      MemRd     = 1'b0;
      MemWr     = 1'b0;
      RegWre    = 1'b0;
      RegDst    = 1'b0;
      DBDataSrc = 1'b0;
      Halted    = 1'b0;
      case (state_q)
         S_IF: begin
            IRWre   = 1'b1;
            state_d = S_ID;
         end
         S_ID: begin
            unique case (1'b1)
               is_hlt: state_d = S_HALT;
               is_jmp: begin
                  PCWre   = 1'b1;
                  PCSrc   = 2'b10;
                  state_d = S_IF;
               end
               is_ill: begin
                  PCWre   = 1'b1;
                  state_d = S_IF;
               end
               default: state_d = S_EXE;
            endcase
         end
         S_EXE: begin
            ALUC    = dec_aluc;
            ALUSrcB = dec_srcb;
            if (is_br) begin
               // slt result 1 (Zero low) means rs < rt: take it
               PCWre   = 1'b1;
               PCSrc   = Zero ? 2'b00 : 2'b01;
               state_d = S_IF;
            end else if (is_ld || is_st) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            ALUC    = dec_aluc;
            ALUSrcB = dec_srcb;
            if (is_st) begin
               MemWr   = 1'b1;
               PCWre   = 1'b1;
               state_d = S_IF;
            end else begin
               MemRd   = 1'b1;
               state_d = S_WB;
            end
         end
         S_WB: begin
            ALUC      = dec_aluc;
            ALUSrcB   = dec_srcb;
            RegWre    = 1'b1;
            PCWre     = 1'b1;
            RegDst    = is_r;
            DBDataSrc = is_ld;
            state_d   = S_IF;
         end
         S_HALT: Halted = 1'b1;
         default: state_d = S_IF;
      endcase
      // Reset must mask every strobe at once, not at the next edge
      if (Reset) begin
         PCWre     = 1'b0;
         PCSrc     = 2'b00;
         IRWre     = 1'b0;
         ALUSrcB   = 1'b0;
         ALUC      = ALU_ADD;
         MemRd     = 1'b0;
         MemWr     = 1'b0;
         RegWre    = 1'b0;
         RegDst    = 1'b0;
         DBDataSrc = 1'b0;
         Halted    = 1'b0;
      end
   end

endmodule
